// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite master.
// A valid/ready command port is turned into exactly one AXI4-Lite read or
// write; the slave's data and response come back on a valid/ready response
// port. All outputs are registered. AW and W may complete in either order.
// C_M_AXI_DATA_WIDTH is intended to be 32 or 64.
module axil_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_areset,
    // command port
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response port
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              busy,
    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD_A = 3'd3,
        RD_R = 3'd4,
        RSP  = 3'd5
    } state_t;

    state_t                          state_reg, state_next;
    logic                            cmd_ready_reg, cmd_ready_next;
    logic                            busy_reg, busy_next;
    logic                            write_reg, write_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]               wstrb_reg, wstrb_next;
    logic                            awvalid_reg, awvalid_next;
    logic                            wvalid_reg, wvalid_next;
    logic                            aw_done_reg, aw_done_next;
    logic                            w_done_reg, w_done_next;
    logic                            bready_reg, bready_next;
    logic                            arvalid_reg, arvalid_next;
    logic                            rready_reg, rready_next;
    logic                            rsp_valid_reg, rsp_valid_next;
    logic                            rsp_write_reg, rsp_write_next;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]                      rsp_resp_reg, rsp_resp_next;

    logic aw_hs;
    logic w_hs;

    // Handshakes on the two write request channels, tracked independently.
    assign aw_hs = awvalid_reg & m_axi_awready;
    assign w_hs  = wvalid_reg & m_axi_wready;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        write_next     = write_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_write_next = rsp_write_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    write_next     = cmd_write;
                    addr_next      = cmd_addr;
                    wdata_next     = cmd_wdata;
                    wstrb_next     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                        state_next   = WR;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_A;
                    end
                end
            end
            WR: begin
                if (aw_hs) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                // Both channels done, counting a handshake landing this cycle.
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    bready_next = 1'b1;
                    state_next  = WR_B;
                end
            end
            WR_B: begin
                if (m_axi_bvalid) begin
                    bready_next    = 1'b0;
                    rsp_resp_next  = m_axi_bresp;
                    rsp_rdata_next = '0;
                    rsp_write_next = write_reg;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end
            RD_A: begin
                if (m_axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_R;
                end
            end
            RD_R: begin
                if (m_axi_rvalid) begin
                    rready_next    = 1'b0;
                    rsp_rdata_next = m_axi_rdata;
                    rsp_resp_next  = m_axi_rresp;
                    rsp_write_next = write_reg;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                cmd_ready_next = 1'b1;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= 2'b00;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            busy_reg      <= busy_next;
            write_reg     <= write_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_write_reg <= rsp_write_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
        end
    end

    assign cmd_ready     = cmd_ready_reg;
    assign busy          = busy_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_write     = rsp_write_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: a 4-register AXI4-Lite CSR slave with
// programmable per-channel wait states, a protocol monitor, and a
// reference register file updated byte by byte from each command.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        m_axi_areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axil_cmd_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32)) dut (
        .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- slave configuration ----------------
    int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // ---------------- slave model ----------------
    logic [31:0] sl_mem [4];
    logic        sl_have_aw, sl_have_w, sl_b_pend, sl_r_pend;
    logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
    logic [3:0]  sl_wstrb;
    int          aw_c, w_c, ar_c, b_c, r_c;

    wire aw_hs = m_axi_awvalid && m_axi_awready;
    wire w_hs  = m_axi_wvalid && m_axi_wready;
    wire b_hs  = m_axi_bvalid && m_axi_bready;
    wire ar_hs = m_axi_arvalid && m_axi_arready;
    wire r_hs  = m_axi_rvalid && m_axi_rready;
    wire [31:0] eff_awaddr = aw_hs ? m_axi_awaddr : sl_awaddr;
    wire [31:0] eff_wdata  = w_hs ? m_axi_wdata : sl_wdata;
    wire [3:0]  eff_wstrb  = w_hs ? m_axi_wstrb : sl_wstrb;
    wire        wr_go = (sl_have_aw || aw_hs) && (sl_have_w || w_hs) && !sl_b_pend;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // AW ready: raised after aw_d waiting cycles, idle-high when aw_d == 0
    always @(posedge clk) begin
        if (m_axi_areset) begin
            m_axi_awready <= 1'b0; aw_c <= 0;
        end else if (aw_hs) begin
            m_axi_awready <= (aw_d == 0); aw_c <= 0;
        end else if (!m_axi_awready) begin
            if (aw_d == 0) m_axi_awready <= 1'b1;
            else if (m_axi_awvalid) begin
                aw_c <= aw_c + 1;
                if (aw_c + 1 >= aw_d) m_axi_awready <= 1'b1;
            end
        end else if (!m_axi_awvalid && aw_d != 0) m_axi_awready <= 1'b0;
    end

    // W ready: same policy with w_d
    always @(posedge clk) begin
        if (m_axi_areset) begin
            m_axi_wready <= 1'b0; w_c <= 0;
        end else if (w_hs) begin
            m_axi_wready <= (w_d == 0); w_c <= 0;
        end else if (!m_axi_wready) begin
            if (w_d == 0) m_axi_wready <= 1'b1;
            else if (m_axi_wvalid) begin
                w_c <= w_c + 1;
                if (w_c + 1 >= w_d) m_axi_wready <= 1'b1;
            end
        end else if (!m_axi_wvalid && w_d != 0) m_axi_wready <= 1'b0;
    end

    // AR ready: same policy with ar_d
    always @(posedge clk) begin
        if (m_axi_areset) begin
            m_axi_arready <= 1'b0; ar_c <= 0;
        end else if (ar_hs) begin
            m_axi_arready <= (ar_d == 0); ar_c <= 0;
        end else if (!m_axi_arready) begin
            if (ar_d == 0) m_axi_arready <= 1'b1;
            else if (m_axi_arvalid) begin
                ar_c <= ar_c + 1;
                if (ar_c + 1 >= ar_d) m_axi_arready <= 1'b1;
            end
        end else if (!m_axi_arvalid && ar_d != 0) m_axi_arready <= 1'b0;
    end

    // Capture AW/W independently until both are present
    always @(posedge clk) begin
        if (m_axi_areset) begin
            sl_have_aw <= 1'b0; sl_have_w <= 1'b0;
            sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0;
        end else begin
            if (aw_hs) sl_awaddr <= m_axi_awaddr;
            if (w_hs) begin sl_wdata <= m_axi_wdata; sl_wstrb <= m_axi_wstrb; end
            if (wr_go) begin sl_have_aw <= 1'b0; sl_have_w <= 1'b0; end
            else begin
                if (aw_hs) sl_have_aw <= 1'b1;
                if (w_hs) sl_have_w <= 1'b1;
            end
        end
    end

    // Register write and B channel
    always @(posedge clk) begin
        if (m_axi_areset) begin
            for (int i = 0; i < 4; i++) sl_mem[i] <= '0;
            sl_b_pend <= 1'b0; m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00; b_c <= 0;
        end else if (wr_go) begin
            sl_mem[eff_awaddr[3:2]] <= merge(sl_mem[eff_awaddr[3:2]], eff_wdata, eff_wstrb);
            sl_b_pend <= 1'b1; b_c <= 0;
            m_axi_bvalid <= (b_d == 0); m_axi_bresp <= bresp_cfg;
        end else if (sl_b_pend) begin
            if (b_hs) begin m_axi_bvalid <= 1'b0; sl_b_pend <= 1'b0; end
            else if (!m_axi_bvalid) begin
                b_c <= b_c + 1;
                if (b_c + 1 >= b_d) m_axi_bvalid <= 1'b1;
            end
        end
    end

    // Read data channel
    always @(posedge clk) begin
        if (m_axi_areset) begin
            sl_r_pend <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rdata <= '0;
            m_axi_rresp <= 2'b00; r_c <= 0; sl_araddr <= '0;
        end else if (ar_hs) begin
            sl_araddr <= m_axi_araddr; sl_r_pend <= 1'b1; r_c <= 0;
            m_axi_rvalid <= (r_d == 0);
            m_axi_rdata <= sl_mem[m_axi_araddr[3:2]]; m_axi_rresp <= rresp_cfg;
        end else if (sl_r_pend) begin
            if (r_hs) begin m_axi_rvalid <= 1'b0; sl_r_pend <= 1'b0; end
            else if (!m_axi_rvalid) begin
                r_c <= r_c + 1;
                if (r_c + 1 >= r_d) m_axi_rvalid <= 1'b1;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int cyc = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, proto_err = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, bready_cyc = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic p_rspv = 0, p_rspr = 0, p_rw = 0, p_bready = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0, p_rdata = 0;
    logic [3:0]  p_wstrb = 0;
    logic [1:0]  p_resp = 0;
    logic mon_aw = 0, mon_w = 0, mon_rd = 0;

    wire [6:0] viol = {
        p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awaddr),
        p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wstrb != p_wstrb),
        p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_araddr),
        p_rspv && !p_rspr && (!rsp_valid || rsp_rdata != p_rdata || rsp_resp != p_resp || rsp_write != p_rw),
        m_axi_bready && !(mon_aw && mon_w),
        m_axi_arvalid && mon_rd,
        (m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid
    };

    // Track handshake counts/timing and flag protocol violations
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (aw_hs) begin aw_n <= aw_n + 1; aw_hs_cyc <= cyc; end
        if (w_hs) begin w_n <= w_n + 1; w_hs_cyc <= cyc; end
        if (b_hs) b_n <= b_n + 1;
        if (ar_hs) ar_n <= ar_n + 1;
        if (m_axi_bready && !p_bready) bready_cyc <= cyc;
        if (m_axi_areset) begin
            p_awv <= 0; p_wv <= 0; p_arv <= 0; p_rspv <= 0; p_bready <= 0;
            mon_aw <= 0; mon_w <= 0; mon_rd <= 0;
        end else begin
            proto_err <= proto_err + $countones(viol);
            p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awaddr <= m_axi_awaddr;
            p_wv <= m_axi_wvalid; p_wr <= m_axi_wready; p_wdata <= m_axi_wdata; p_wstrb <= m_axi_wstrb;
            p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_araddr <= m_axi_araddr;
            p_rspv <= rsp_valid; p_rspr <= rsp_ready; p_rdata <= rsp_rdata;
            p_resp <= rsp_resp; p_rw <= rsp_write; p_bready <= m_axi_bready;
            if (b_hs) begin mon_aw <= 0; mon_w <= 0; end
            else begin
                if (aw_hs) mon_aw <= 1;
                if (w_hs) mon_w <= 1;
            end
            if (r_hs) mon_rd <= 0; else if (ar_hs) mon_rd <= 1;
        end
    end

    // ---------------- reference model and bookkeeping ----------------
    int errors = 0, checks = 0;
    logic [31:0] ref_mem [4] = '{default: 32'h0};

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = ref_mem[addr[3:2]];
        for (int b = 0; b < 4; b++)
            if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[addr[3:2]] = v;
    endtask

    // One command through the port; returns response fields and whether the
    // first AXI VALID was visible exactly one cycle after accept.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int rsp_dly,
                          output logic [31:0] rd, output logic [1:0] resp, output logic rw,
                          output logic lat_ok, output logic ok);
        int n;
        ok = 1'b1; lat_ok = 1'b0; rd = 'x; resp = 'x; rw = 'x;
        n = 0;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin ok = 1'b0; return; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat_ok = wr ? (m_axi_awvalid && m_axi_wvalid && !m_axi_arvalid)
                    : (m_axi_arvalid && !m_axi_awvalid && !m_axi_wvalid);
        n = 0;
        while (!rsp_valid && n < 500) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) begin ok = 1'b0; return; end
        repeat (rsp_dly) begin @(posedge clk); #1; end
        rd = rsp_rdata; resp = rsp_resp; rw = rsp_write;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn %s addr=%h wdata=%h wstrb=%h -> rdata=%h resp=%0d write=%0d",
                 wr ? "WR" : "RD", addr, wd, ws, rd, resp, rw);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        m_axi_areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b000) begin errors++;
            $display("FAIL reset_valids: got %b want 000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}); end
        checks++; if ({m_axi_bready, m_axi_rready, rsp_valid} !== 3'b000) begin errors++;
            $display("FAIL reset_readies: got %b want 000", {m_axi_bready, m_axi_rready, rsp_valid}); end
        checks++; if ({rsp_write, rsp_resp, rsp_rdata} !== 35'h0) begin errors++;
            $display("FAIL reset_rsp: got %h want 0", {rsp_write, rsp_resp, rsp_rdata}); end
        checks++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== 68'h0) begin errors++;
            $display("FAIL reset_capture: got %h want 0", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}); end
        checks++; if ({m_axi_awprot, m_axi_arprot} !== 6'b0) begin errors++;
            $display("FAIL prot: got %b want 000000", {m_axi_awprot, m_axi_arprot}); end
        m_axi_areset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic [1:0] resp; logic rw, lat, ok;
        do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, rd, resp, rw, lat, ok);
        ref_write(32'h4, 32'hDEADBEEF, 4'hF);
        checks++; if (!ok) begin errors++; $display("FAIL wr_timeout: got timeout want response"); end
        checks++; if (lat !== 1'b1) begin errors++; $display("FAIL wr_valid_latency: got %b want 1", lat); end
        checks++; if ({rw, resp, rd} !== {1'b1, 2'b00, 32'h0}) begin errors++;
            $display("FAIL wr_rsp: got w=%b resp=%b rdata=%h want w=1 resp=00 rdata=0", rw, resp, rd); end
        do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, resp, rw, lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_timeout: got timeout want response"); end
        checks++; if (lat !== 1'b1) begin errors++; $display("FAIL rd_valid_latency: got %b want 1", lat); end
        checks++; if ({rw, resp, rd} !== {1'b0, 2'b00, 32'hDEADBEEF}) begin errors++;
            $display("FAIL rd_rsp: got w=%b resp=%b rdata=%h want w=0 resp=00 rdata=deadbeef", rw, resp, rd); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic [1:0] resp; logic rw, lat, ok;
        do_cmd(1'b1, 32'h8, 32'h11223344, 4'hF, 0, rd, resp, rw, lat, ok);
        ref_write(32'h8, 32'h11223344, 4'hF);
        do_cmd(1'b1, 32'h8, 32'hAABBCCDD, 4'h3, 1, rd, resp, rw, lat, ok);
        ref_write(32'h8, 32'hAABBCCDD, 4'h3);
        do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, resp, rw, lat, ok);
        checks++; if (!ok || rd !== 32'h1122CCDD) begin errors++;
            $display("FAIL strobe_merge: got %h (ok=%b) want 1122ccdd", rd, ok); end
    endtask

    task automatic test_wr_order();
        int awd [3] = '{4, 1, 2};
        int wd [3]  = '{1, 4, 2};
        int diff [3] = '{3, -3, 0};
        logic [31:0] rd, data; logic [1:0] resp; logic rw, lat, ok;
        int b0, a0, last;
        for (int k = 0; k < 3; k++) begin
            aw_d = awd[k]; w_d = wd[k]; b_d = k;
            b0 = b_n; a0 = aw_n;
            data = $urandom;
            do_cmd(1'b1, 32'hC, data, 4'hF, 0, rd, resp, rw, lat, ok);
            ref_write(32'hC, data, 4'hF);
            repeat (3) @(posedge clk);
            #1;
            last = (aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc;
            checks++; if (!ok || resp !== 2'b00 || rw !== 1'b1) begin errors++;
                $display("FAIL order%0d_rsp: got ok=%b resp=%b w=%b want ok=1 resp=00 w=1", k, ok, resp, rw); end
            checks++; if (aw_hs_cyc - w_hs_cyc != diff[k]) begin errors++;
                $display("FAIL order%0d_hs_gap: got %0d want %0d", k, aw_hs_cyc - w_hs_cyc, diff[k]); end
            checks++; if (bready_cyc != last + 1) begin errors++;
                $display("FAIL order%0d_bready_rise: got cycle %0d want %0d", k, bready_cyc, last + 1); end
            checks++; if (b_n - b0 != 1 || aw_n - a0 != 1) begin errors++;
                $display("FAIL order%0d_counts: got b=%0d aw=%0d want 1 1", k, b_n - b0, aw_n - a0); end
        end
        aw_d = 0; w_d = 0; b_d = 0;
        do_cmd(1'b0, 32'hC, 32'h0, 4'h0, 0, rd, resp, rw, lat, ok);
        checks++; if (!ok || rd !== ref_mem[3]) begin errors++;
            $display("FAIL order_readback: got %h want %h", rd, ref_mem[3]); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] resp; logic rw, lat, ok;
        int b0, a0, r0;
        bresp_cfg = 2'b10; rresp_cfg = 2'b11;
        b0 = b_n; a0 = aw_n;
        do_cmd(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 3, rd, resp, rw, lat, ok);
        ref_write(32'h0, 32'h5A5A5A5A, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (!ok || resp !== 2'b10) begin errors++; $display("FAIL slverr_bresp: got %b want 10", resp); end
        checks++; if (b_n - b0 != 1 || aw_n - a0 != 1) begin errors++;
            $display("FAIL slverr_no_retry: got b=%0d aw=%0d want 1 1", b_n - b0, aw_n - a0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL slverr_busy: got %b want 0", busy); end
        r0 = ar_n;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 2, rd, resp, rw, lat, ok);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (!ok || resp !== 2'b11 || rd !== ref_mem[0]) begin errors++;
            $display("FAIL decerr_rresp: got resp=%b rdata=%h want 11 %h", resp, rd, ref_mem[0]); end
        checks++; if (ar_n - r0 != 1 || busy !== 1'b0) begin errors++;
            $display("FAIL decerr_no_retry: got ar=%0d busy=%b want 1 0", ar_n - r0, busy); end
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] got [3];
        int acc_cyc [3];
        int nacc = 0, nrsp = 0, hi = 0, a0;
        a0 = ar_n;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addrs[0]; rsp_ready = 1'b1;
        for (int c = 0; c < 60 && nrsp < 3; c++) begin
            if (cmd_ready) begin
                hi++;
                if (cmd_valid && nacc < 3) begin acc_cyc[nacc] = c; nacc++; end
            end
            if (rsp_valid) begin got[nrsp] = rsp_rdata; nrsp++; end
            @(posedge clk); #1;
            if (nacc < 3) cmd_addr = addrs[nacc]; else cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (nacc != 3 || nrsp != 3 || hi != 3) begin errors++;
            $display("FAIL b2b_counts: got acc=%0d rsp=%0d ready_cycles=%0d want 3 3 3", nacc, nrsp, hi); end
        checks++; if (ar_n - a0 != 3) begin errors++; $display("FAIL b2b_ar_count: got %0d want 3", ar_n - a0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (i < nrsp && got[i] !== ref_mem[addrs[i][3:2]]) begin errors++;
                $display("FAIL b2b_rdata%0d: got %h want %h", i, got[i], ref_mem[addrs[i][3:2]]); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (nacc == 3 && acc_cyc[i+1] - acc_cyc[i] != 4) begin errors++;
                $display("FAIL b2b_spacing%0d: got %0d want 4", i, acc_cyc[i+1] - acc_cyc[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd, data; logic [1:0] resp; logic rw, lat, ok;
        int n = 0;
        r_d = 20;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!m_axi_rready && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (m_axi_rready !== 1'b1) begin errors++; $display("FAIL midrst_reach_rd_r: got rready=%b want 1", m_axi_rready); end
        m_axi_areset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({m_axi_rready, rsp_valid, cmd_ready, busy, m_axi_arvalid} !== 5'b00100) begin errors++;
            $display("FAIL midrst_state: got rready/rspv/cmdrdy/busy/arv=%b want 00100",
                     {m_axi_rready, rsp_valid, cmd_ready, busy, m_axi_arvalid}); end
        m_axi_areset = 1'b0;
        r_d = 0;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        data = $urandom;
        do_cmd(1'b1, 32'h0, data, 4'hF, 0, rd, resp, rw, lat, ok);
        ref_write(32'h0, data, 4'hF);
        checks++; if (!ok || resp !== 2'b00 || rw !== 1'b1) begin errors++;
            $display("FAIL midrst_write: got ok=%b resp=%b w=%b want 1 00 1", ok, resp, rw); end
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, resp, rw, lat, ok);
        checks++; if (!ok || rd !== data) begin errors++; $display("FAIL midrst_readback: got %h want %h", rd, data); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, data, exp_rd; logic [3:0] strb; logic [1:0] resp;
        logic rw, lat, ok, wr;
        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 15);
            data = $urandom; strb = 4'($urandom_range(0, 15));
            aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
            ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
            exp_rd = wr ? 32'h0 : ref_mem[addr[3:2]];
            do_cmd(wr, addr, data, strb, $urandom_range(0, 2), rd, resp, rw, lat, ok);
            if (wr) ref_write(addr, data, strb);
            checks++; if (!ok || lat !== 1'b1 || rw !== wr || resp !== 2'b00 || rd !== exp_rd) begin errors++;
                $display("FAIL rand%0d: got ok=%b lat=%b w=%b resp=%b rdata=%h want 1 1 %b 00 %h",
                         t, ok, lat, rw, resp, rd, wr, exp_rd); end
            checks++; if ((wr ? sl_awaddr : sl_araddr) !== addr) begin errors++;
                $display("FAIL rand%0d_addr: got %h want %h", t, wr ? sl_awaddr : sl_araddr, addr); end
        end
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_wr_order();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (proto_err != 0) begin errors++; $display("FAIL protocol_monitor: got %0d violations want 0", proto_err); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog in case a task loop misbehaves
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master; the initiator side of the protocol our CSR slaves implement.
- Turns a simple valid/ready command port into one AXI4-Lite read or write, then returns data and response on a valid/ready response port.
- Used by on-chip sequencers and SPI/JTAG bridges to drive CSR blocks without a CPU.
- AW and W channels complete independently and in either order.

Parameters:
C_M_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64 only.
C_M_AXI_ADDR_WIDTH, 32, AXI address width.

Ports:
m_axi_aclk  in  1  clock; the only clock.
m_axi_areset  in  1  reset, synchronous, active-high.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address, passed through unmodified.
cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write strobes.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
rsp_write  out  1  echo of cmd_write.
rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP from the slave.
busy  out  1  high in any state other than IDLE.
m_axi_awaddr, m_axi_awprot(3), m_axi_awvalid, m_axi_awready(in), m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready(in), m_axi_bresp(in,2), m_axi_bvalid(in), m_axi_bready, m_axi_araddr, m_axi_arprot(3), m_axi_arvalid, m_axi_arready(in), m_axi_rdata(in), m_axi_rresp(in,2), m_axi_rvalid(in), m_axi_rready: standard AXI4-Lite master signals.

Behaviour:
- Every output is driven from a register.
- awprot/arprot are tied to 3'b000.
- Reset values:
  - state = IDLE.
  - cmd_ready = 1.
  - All AXI valids, bready, rready, rsp_valid and busy = 0.
  - rsp_rdata, rsp_resp, rsp_write = 0.
  - Captured addr/data/strb = 0.
- States: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - cmd_ready = 1.
  - On accept: capture addr, wdata, wstrb, write; cmd_ready drops next cycle.
  - Write: next cycle awvalid = 1, wvalid = 1, state WR.
  - Read: next cycle arvalid = 1, state RD_A.
  - The first AXI VALID appears exactly 1 cycle after command accept.
- WR:
  - awvalid deasserts the cycle after awready is sampled high while awvalid = 1; sets aw_done.
  - wvalid deasserts the cycle after wready is sampled high while wvalid = 1; sets w_done.
  - Same-cycle awready & wready: both done together.
  - When both done (including the same-cycle case), next cycle: bready = 1, state WR_B.
  - VALIDs never drop before their handshake.
  - awaddr/wdata/wstrb stay stable while the corresponding VALID is high.
- WR_B:
  - bready = 1 until bvalid seen.
  - Then capture bresp into rsp_resp, rsp_rdata = 0, rsp_write = 1; bready = 0, rsp_valid = 1, state RSP.
  - bready is 0 in all other states; a bvalid arriving early stalls until WR_B.
- RD_A: arvalid held until arready sampled high, then arvalid = 0, rready = 1, state RD_R.
- RD_R: on rvalid & rready, capture rdata and rresp, rsp_write = 0; rready = 0, rsp_valid = 1, state RSP.
- RSP:
  - rsp_valid held with stable data until rsp_ready.
  - Then rsp_valid = 0, cmd_ready = 1, state IDLE.
  - Minimum command-to-command spacing: accept, 1 cycle AXI address/data, 1 cycle B/R, 1 cycle RSP.
- Exactly one transaction is outstanding; cmd_valid is ignored while busy.
- SLVERR/DECERR responses are returned verbatim, with no retry.
- Slave stalls are unbounded; the block waits indefinitely.
- Reset asserted mid-transaction: all state returns to reset values on the next clock edge, in-flight response dropped. Slave-side cleanup is the system's responsibility (shared reset).
- Address bits are not aligned or masked; low bits go out as given.

Test Plan:
- Write 0xDEADBEEF to 0x4 with wstrb 0xF to a 4-register CSR slave, then read 0x4 -> write rsp_resp = 0, rsp_write = 1, rsp_rdata = 0; read rsp_rdata = 0xDEADBEEF, rsp_resp = 0.
- Write 0x11223344 to 0x8 with wstrb 0xF, then write 0xAABBCCDD with wstrb 0x3, then read 0x8 -> 0x1122CCDD.
- Slave model asserts wready 3 cycles before awready, then the reverse order, then the same cycle -> each VALID holds until its own handshake; bready rises only after both; exactly one B accepted per command.
- Slave returns bresp = 2'b10 and rresp = 2'b11 -> rsp_resp echoes 2'b10 and 2'b11; no retry; busy returns to 0 after rsp_ready.
- cmd_valid held high across 3 back-to-back reads with rsp_ready tied high and a zero-wait slave -> cmd_ready pulses once per transaction, 3 responses delivered in order, no overlap on AR.
- Assert m_axi_areset while in RD_R -> next cycle rready = 0, rsp_valid = 0, cmd_ready = 1; a following write completes normally.
